// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem addressing, 2-entry instruction buffer, branch redirect.
// Optional zero-word halt detection is enabled by defining FETCH_HALT_DETECT_EN.
//
// state | meaning
// FETCH | fetching sequentially whenever the buffer has room (or is popping)
// HALT  | all-zero word seen; no fetch, buffer drains; left only by redirect or reset
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [15:0] pc_out,
  output logic        halted
);

  // MEM_DEPTH is a power of two, so the wrap of a redirect target is a mask
  localparam logic [15:0] PC_LAST = 16'(MEM_DEPTH - 1);
  localparam logic [15:0] PC_MASK = PC_LAST;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [1:0]  count;
  logic [15:0] pc0, pc1;
  logic [31:0] ins0, ins1;

  logic        pop;
  logic        fetch_en;
  logic        zero_hit;
  logic        push;
  logic [15:0] pc_next;

  assign pop      = (count != 2'd0) & inst_ready;
  assign fetch_en = (state == FETCH) & ~stall & ~redirect & ((count != 2'd2) | pop);

`ifdef FETCH_HALT_DETECT_EN
  assign zero_hit = fetch_en & (imem_data == 32'h0);
`else
  assign zero_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign push    = fetch_en & ~zero_hit;
  assign pc_next = (pc == PC_LAST) ? 16'h0000 : pc + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      count <= 2'd0;
      pc0   <= 16'h0;
      pc1   <= 16'h0;
      ins0  <= 32'h0;
      ins1  <= 32'h0;
`ifdef FETCH_HALT_DETECT_EN
      halted <= 1'b0;
`endif
    end else if (redirect) begin
      // flush wins over any pop or push in the same cycle
      state <= FETCH;
      pc    <= redirect_pc & PC_MASK;
      count <= 2'd0;
`ifdef FETCH_HALT_DETECT_EN
      halted <= 1'b0;
`endif
    end else begin
      if (push)
        pc <= pc_next;
`ifdef FETCH_HALT_DETECT_EN
      if (zero_hit) begin
        state  <= HALT;
        halted <= 1'b1;
      end
`endif
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            pc0  <= pc;
            ins0 <= imem_data;
          end else begin
            pc1  <= pc;
            ins1 <= imem_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0   <= pc1;
          ins0  <= ins1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            pc0  <= pc;
            ins0 <= imem_data;
          end else begin
            pc0  <= pc1;
            ins0 <= ins1;
            pc1  <= pc;
            ins1 <= imem_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign inst_valid = (count != 2'd0);
  assign inst_out   = inst_valid ? ins0 : 32'h0;
  assign pc_out     = inst_valid ? pc0 : 16'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirect, wrap, stall, zero word, reset.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [15:0] pc_out;
  logic        halted;

  logic [31:0] mem [256];
  int          n_chk;
  int          n_fail;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  assign imem_data = (imem_addr < 16'd256) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input int p);
    check({tag, " valid"}, 32'(inst_valid), 32'd1);
    check({tag, " pc"}, 32'(pc_out), 32'(p));
    check({tag, " inst"}, inst_out, w(p));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = w(i);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    inst_ready = 1'b1;

    // reset values
    #1;
    check("rst valid", 32'(inst_valid), 32'd0);
    check("rst inst", inst_out, 32'h0);
    check("rst pc_out", 32'(pc_out), 32'h0);
    check("rst addr", 32'(imem_addr), 32'h0);
    check("rst halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // streaming 0..3 one per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("stream", i);
      check("stream addr", 32'(imem_addr), 32'(i + 1));
    end

    // back-pressure: buffer fills to 2 and holds
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("bp hold", 3);
      check("bp addr", 32'(imem_addr), 32'd5);
    end
    inst_ready = 1'b1;
    step();
    check_head("bp rel0", 4);
    check("bp rel addr", 32'(imem_addr), 32'd6);
    step();
    check_head("bp rel1", 5);

    // redirect with two entries buffered
    redirect = 1'b1;
    redirect_pc = 16'h001C;
    step();
    redirect = 1'b0;
    check("redir valid", 32'(inst_valid), 32'd0);
    check("redir addr", 32'(imem_addr), 32'h1C);
    step();
    check_head("redir tgt", 16'h1C);

    // out-of-range target wraps, then PC wraps at 255
    redirect = 1'b1;
    redirect_pc = 16'h01FE;
    step();
    redirect = 1'b0;
    check("wrap tgt addr", 32'(imem_addr), 32'hFE);
    step();
    check_head("wrap fe", 16'hFE);
    step();
    check_head("wrap ff", 16'hFF);
    check("wrap addr", 32'(imem_addr), 32'h0);
    step();
    check_head("wrap 0", 0);
    check("wrap addr1", 32'(imem_addr), 32'd1);

    // stall for 3 cycles, redirect in the middle one
    stall = 1'b1;
    step();
    check("stall drain", 32'(inst_valid), 32'd0);
    check("stall addr", 32'(imem_addr), 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("stall redir addr", 32'(imem_addr), 32'h40);
    step();
    check("stall hold addr", 32'(imem_addr), 32'h40);
    check("stall hold valid", 32'(inst_valid), 32'd0);
    stall = 1'b0;
    step();
    check_head("stall tgt", 16'h40);
    check("stall tgt addr", 32'(imem_addr), 32'h41);

    // all-zero word at address 5
    mem[5] = 32'h0;
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_head("zero pre", i);
    end
    step();
`ifdef FETCH_HALT_DETECT_EN
    check("halt valid", 32'(inst_valid), 32'd0);
    check("halt flag", 32'(halted), 32'd1);
    check("halt addr", 32'(imem_addr), 32'd5);
    step();
    check("halt hold addr", 32'(imem_addr), 32'd5);
    check("halt hold flag", 32'(halted), 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    check("unhalt flag", 32'(halted), 32'd0);
    check("unhalt addr", 32'(imem_addr), 32'd0);
    step();
    check_head("unhalt refetch", 0);
`else
    check("zero valid", 32'(inst_valid), 32'd1);
    check("zero pc", 32'(pc_out), 32'd5);
    check("zero inst", inst_out, 32'h0);
    check("zero halted", 32'(halted), 32'd0);
    check("zero addr", 32'(imem_addr), 32'd6);
    step();
    check_head("zero next", 6);
`endif

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async valid", 32'(inst_valid), 32'd0);
    check("async addr", 32'(imem_addr), 32'h0);
    check("async pc_out", 32'(pc_out), 32'h0);
    check("async halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_head("post rst", 0);
    check("post rst addr", 32'(imem_addr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
